// File: rtl/mix_duty_feeder.sv
// mix_duty_feeder: joins one sample from each of two channel streams, applies
// a per-channel Q1.7 gain, sums, saturates and converts the result to an
// offset-binary PWM duty value. The duty output only changes at a PWM period
// boundary, so the PWM stage never sees a mid-period change.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   a_sample_i/a_valid_i/a_ready_o   channel A stream (two's complement)
//   b_sample_i/b_valid_i/b_ready_o   channel B stream (two's complement)
//   gain_a_i, gain_b_i        unsigned Q1.7 gains (128 = unity), taken on fire
//   mute_i                    loads midscale instead of the pending sample
//   pwm_enable_i, pwm_counter_i  PWM stage enable and counter
//   duty_cycle_o              registered duty to the PWM stage
//   underrun_o                pulse: period ended with no pending sample
//   underrun_count_o          saturating underrun counter
module mix_duty_feeder #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned CTRVAL   = 256,
  parameter int unsigned CTRLEN   = $clog2(CTRVAL)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] a_sample_i,
  input  logic                a_valid_i,
  output logic                a_ready_o,
  input  logic [SAMPLE_W-1:0] b_sample_i,
  input  logic                b_valid_i,
  output logic                b_ready_o,
  input  logic [7:0]          gain_a_i,
  input  logic [7:0]          gain_b_i,
  input  logic                mute_i,
  input  logic                pwm_enable_i,
  input  logic [CTRLEN-1:0]   pwm_counter_i,
  output logic [CTRLEN-1:0]   duty_cycle_o,
  output logic                underrun_o,
  output logic [7:0]          underrun_count_o
);

  localparam int unsigned PW  = SAMPLE_W + 9;
  localparam int unsigned SW2 = SAMPLE_W + 10;

  localparam logic [CTRLEN-1:0]     Midscale  = {1'b1, {(CTRLEN-1){1'b0}}};
  localparam logic [CTRLEN-1:0]     LastCount = CTRLEN'(CTRVAL - 1);
  localparam logic signed [SW2-1:0] SatMax    = SW2'((1 << (SAMPLE_W - 1)) - 1);
  // ~max == -max-1, the most negative representable sample
  localparam logic signed [SW2-1:0] SatMin    = ~SatMax;

  logic                  s1_valid_q, s1_valid_d;
  logic signed [PW-1:0]  pa_q, pa_d, pb_q, pb_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [CTRLEN-1:0]     pend_q, pend_d;
  logic [CTRLEN-1:0]     duty_q, duty_d;
  logic [7:0]            ucnt_q, ucnt_d;

  logic period_end, s1_adv, in_ready, fire, miss;

  logic signed [PW-1:0]  a_ext, b_ext, ga_ext, gb_ext;
  logic signed [SW2-1:0] sum, shifted;
  logic [SAMPLE_W-1:0]   sat, obin;

  assign period_end = pwm_enable_i & (pwm_counter_i == LastCount);
  assign s1_adv     = s1_valid_q & (~s2_valid_q | period_end);
  assign in_ready   = ~s1_valid_q | s1_adv;
  // Each side's ready depends on the other's valid so both are taken together.
  assign a_ready_o  = in_ready & b_valid_i & ~rst;
  assign b_ready_o  = in_ready & a_valid_i & ~rst;
  assign fire       = a_valid_i & b_valid_i & in_ready & ~rst;
  assign miss       = period_end & ~s2_valid_q;

  assign underrun_o       = miss & ~rst;
  assign duty_cycle_o     = duty_q;
  assign underrun_count_o = ucnt_q;

  // Gain stage: signed sample times zero-extended unsigned gain.
  always_comb begin
    a_ext  = PW'($signed(a_sample_i));
    b_ext  = PW'($signed(b_sample_i));
    ga_ext = PW'({1'b0, gain_a_i});
    gb_ext = PW'({1'b0, gain_b_i});
    pa_d   = a_ext * ga_ext;
    pb_d   = b_ext * gb_ext;
  end

  // Mix stage: sum, drop the Q1.7 fraction, saturate, flip MSB to offset binary.
  always_comb begin
    sum     = SW2'(pa_q) + SW2'(pb_q);
    shifted = sum >>> 7;
    if (shifted > SatMax) begin
      sat = SatMax[SAMPLE_W-1:0];
    end else if (shifted < SatMin) begin
      sat = SatMin[SAMPLE_W-1:0];
    end else begin
      sat = shifted[SAMPLE_W-1:0];
    end
    obin   = {~sat[SAMPLE_W-1], sat[SAMPLE_W-2:0]};
    pend_d = obin[SAMPLE_W-1 -: CTRLEN];
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    duty_d     = duty_q;
    ucnt_d     = ucnt_q;

    if (fire) begin
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // A refill from S1 wins over the clear on a period boundary.
    if (s1_adv) begin
      s2_valid_d = 1'b1;
    end else if (period_end) begin
      s2_valid_d = 1'b0;
    end

    if (period_end && s2_valid_q) begin
      duty_d = mute_i ? Midscale : pend_q;
    end

    if (miss && (ucnt_q != 8'hFF)) begin
      ucnt_d = ucnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      duty_q     <= Midscale;
      ucnt_q     <= 8'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      duty_q     <= duty_d;
      ucnt_q     <= ucnt_d;
    end
  end

  // Data registers carry no reset; their valid flags qualify them.
  always_ff @(posedge clk) begin
    if (fire) begin
      pa_q <= pa_d;
      pb_q <= pb_d;
    end
    if (s1_adv) begin
      pend_q <= pend_d;
    end
  end

endmodule
